// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   MULDIV_DATA_WIDTH : default operand/result width
//   op_e              : M-extension funct3 encodings
//   state_e           : sequencing states of alu_muldiv
package muldiv_pkg;

   localparam int MULDIV_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core -- restoring divider on unsigned magnitudes, one quotient
// bit per step. The caller loads the operands, issues DATA_WIDTH steps and
// samples o_quo_next/o_rem_next on the last step (the values the registers
// would take), so the sign fix-up can be folded into that same edge.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_load               capture i_dividend / i_divisor, clear remainder
//   i_step               perform one restoring iteration
//   i_dividend/divisor   operand magnitudes
//   o_quo_next/rem_next  quotient/remainder after the current iteration
module muldiv_div_core
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = MULDIV_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic                  i_step,
   input  logic [DATA_WIDTH-1:0] i_dividend,
   input  logic [DATA_WIDTH-1:0] i_divisor,
   output logic [DATA_WIDTH-1:0] o_quo_next,
   output logic [DATA_WIDTH-1:0] o_rem_next
);

   logic [DATA_WIDTH-1:0] r_rem;
   logic [DATA_WIDTH-1:0] r_quo;
   logic [DATA_WIDTH-1:0] r_dvsr;
   logic [DATA_WIDTH-1:0] w_shift_lo;
   logic [DATA_WIDTH-1:0] w_diff;
   logic                  w_take;

   // The shifted partial remainder is DATA_WIDTH+1 bits wide. If the bit
   // shifted out of r_rem is set the value already exceeds any divisor, so
   // the subtraction can be done on the low DATA_WIDTH bits alone.
   assign w_shift_lo = {r_rem[DATA_WIDTH-2:0], r_quo[DATA_WIDTH-1]};
   assign w_take     = r_rem[DATA_WIDTH-1] | (w_shift_lo >= r_dvsr);
   assign w_diff     = w_shift_lo - r_dvsr;
   assign o_rem_next = w_take ? w_diff : w_shift_lo;
   assign o_quo_next = {r_quo[DATA_WIDTH-2:0], w_take};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvsr <= '0;
      end else if (i_load) begin
         r_rem  <= '0;
         r_quo  <= i_dividend;
         r_dvsr <= i_divisor;
      end else if (i_step) begin
         r_rem  <= o_rem_next;
         r_quo  <= o_quo_next;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative RV32M multiply/divide unit for the Execute stage.
// Multiplies by radix-2 shift-add and divides by restoring division, both on
// operand magnitudes over DATA_WIDTH cycles; the result sign is applied on
// the edge into DONE.
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// divide/remainder ops complete in one cycle with result 0.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         M-extension op present in Execute
//   op_i            funct3 (see muldiv_pkg::op_e)
//   a_i, b_i        rs1 / rs2 operands
//   flush_i         Execute flush; aborts an iterating op
//   busy_o          operation iterating
//   stall_o         freeze Fetch/Decode/Execute registers
//   done_o          one-cycle pulse, result_o valid
//   result_o        registered result, held until the next DONE
module alu_muldiv
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = MULDIV_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int              CW    = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0]   ITERS = CW'(DATA_WIDTH);
   localparam logic [CW-1:0]   ONE   = CW'(1);

   // Conditional two's complement: magnitude extraction and sign fix-up.
   function automatic logic [DATA_WIDTH-1:0] cond_neg(
      input logic [DATA_WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*DATA_WIDTH-1:0] cond_neg_wide(
      input logic [2*DATA_WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   state_e                  r_state;
   op_e                     r_op;
   logic [CW-1:0]           r_cnt;
   logic                    r_neg_res;
   logic [2*DATA_WIDTH-1:0] r_acc;
   logic [2*DATA_WIDTH-1:0] r_mcand;
   logic [DATA_WIDTH-1:0]   r_mplier;
   logic [DATA_WIDTH-1:0]   r_result;

   op_e                     w_op;
   logic                    w_sgn_a;
   logic                    w_sgn_b;
   logic                    w_neg_a;
   logic                    w_neg_b;
   logic [DATA_WIDTH-1:0]   w_mag_a;
   logic [DATA_WIDTH-1:0]   w_mag_b;
   logic                    w_accept;
   logic [2*DATA_WIDTH-1:0] w_acc_next;
   logic [2*DATA_WIDTH-1:0] w_prod;
   logic [DATA_WIDTH-1:0]   w_mul_res;

   assign w_op     = op_e'(op_i);
   assign w_sgn_a  = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                     (w_op == OP_DIV)  || (w_op == OP_REM);
   assign w_sgn_b  = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
   assign w_neg_a  = w_sgn_a & a_i[DATA_WIDTH-1];
   assign w_neg_b  = w_sgn_b & b_i[DATA_WIDTH-1];
   assign w_mag_a  = cond_neg(a_i, w_neg_a);
   assign w_mag_b  = cond_neg(b_i, w_neg_b);
   assign w_accept = (r_state == ST_IDLE) && start_i && !flush_i;

   // Multiplier: the last add is folded into the fix-up so the signed
   // result is ready on the edge into DONE.
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_prod     = cond_neg_wide(w_acc_next, r_neg_res);
   assign w_mul_res  = (r_op == OP_MUL) ? w_prod[DATA_WIDTH-1:0]
                                        : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];

`ifdef MULDIV_DIV_EN
   logic                  r_neg_a;
   logic                  r_b_zero;
   logic                  w_div_step;
   logic [DATA_WIDTH-1:0] w_quo_next;
   logic [DATA_WIDTH-1:0] w_rem_next;
   logic [DATA_WIDTH-1:0] w_div_res;

   assign w_div_step = (r_state == ST_DIV) && !flush_i;

   muldiv_div_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_div_core (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .i_load     (w_accept && op_i[2]),
      .i_step     (w_div_step),
      .i_dividend (w_mag_a),
      .i_divisor  (w_mag_b),
      .o_quo_next (w_quo_next),
      .o_rem_next (w_rem_next)
   );

   // Divide by zero keeps the raw all-ones quotient regardless of signs;
   // the remainder sign always follows the dividend. Signed overflow needs
   // no special case: |MIN|/1 negated wraps back to MIN, remainder 0.
   assign w_div_res = r_op[1] ? cond_neg(w_rem_next, r_neg_a)
                              : (r_b_zero ? '1 : cond_neg(w_quo_next, r_neg_res));
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_IDLE;
         r_op      <= OP_MUL;
         r_cnt     <= '0;
         r_neg_res <= 1'b0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_result  <= '0;
`ifdef MULDIV_DIV_EN
         r_neg_a   <= 1'b0;
         r_b_zero  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op      <= w_op;
                  r_cnt     <= ITERS;
                  r_neg_res <= w_neg_a ^ w_neg_b;
                  r_acc     <= '0;
                  r_mcand   <= {{DATA_WIDTH{1'b0}}, w_mag_a};
                  r_mplier  <= w_mag_b;
                  if (!op_i[2]) begin
                     r_state <= ST_MUL;
                  end else begin
`ifdef MULDIV_DIV_EN
                     r_state  <= ST_DIV;
                     r_neg_a  <= w_neg_a;
                     r_b_zero <= (b_i == '0);
`else
                     r_state  <= ST_DONE;
                     r_result <= '0;
`endif
                  end
               end
            end
            ST_MUL: begin
               if (flush_i) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_acc    <= w_acc_next;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt - ONE;
                  if (r_cnt == ONE) begin
                     r_state  <= ST_DONE;
                     r_result <= w_mul_res;
                  end
               end
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
               if (flush_i) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - ONE;
                  if (r_cnt == ONE) begin
                     r_state  <= ST_DONE;
                     r_result <= w_div_res;
                  end
               end
            end
`endif
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o   = (r_state == ST_MUL) || (r_state == ST_DIV);
   assign done_o   = (r_state == ST_DONE);
   // Gated by reset so the pipeline is never frozen while held in reset.
   assign stall_o  = rst_ni & (w_accept | busy_o);
   assign result_o = r_result;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

   localparam int W = 32;
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          flush = 1'b0;
   logic          busy_o, stall_o, done_o;
   logic [W-1:0]  result_o;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   alu_muldiv #(.DATA_WIDTH(W)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (start),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .flush_i  (flush),
      .busy_o   (busy_o),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of an RV32M op, from plain arithmetic.
   function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] x,
                                          input logic [31:0] y);
      longint     sx, sy;
      logic [63:0] p;
      int          ix, iy;
      ix = x;
      iy = y;
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b011: begin
            sx = (f3 == 3'b001 || f3 == 3'b010) ? longint'($signed(x)) : longint'({32'b0, x});
            sy = (f3 == 3'b001) ? longint'($signed(y)) : longint'({32'b0, y});
            p  = sx * sy;
            return (f3 == 3'b000) ? p[31:0] : p[63:32];
         end
         3'b100: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            return ix / iy;
         end
         3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'b110: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            return ix % iy;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   // Schedule model: an accepted op produces its result after a fixed
   // number of busy cycles; flush aborts, DONE lasts one cycle.
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_res = '0;
   logic [31:0] m_pend = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_done = 1'b0;
         m_res  = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         if (flush) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_res  = m_pend;
            end
         end
      end else if (start && !flush) begin
         m_pend = ref_op(op, a, b);
         if (op[2] && !DIV_EN) begin
            m_done = 1'b1;
            m_res  = '0;
         end else begin
            m_left = W;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic eb, es;
         eb = rst_n && (m_left > 0);
         es = rst_n && (eb || (!m_done && start && !flush));
         chk1("busy_o", busy_o, eb);
         chk1("stall_o", stall_o, es);
         chk1("done_o", done_o, rst_n && m_done);
         chk32("result_o", result_o, m_res);
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Releases start after the accepting edge, then waits (bounded) for done.
   task automatic wait_done(output logic [31:0] res, output int lat, output int bcnt);
      bit seen = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      bcnt = 0;
      res = '0;
      for (int i = 0; i < 100; i++) begin
         lat++;
         if (busy_o) bcnt++;
         if (done_o) begin
            res = result_o;
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!seen) chk1("done_timeout", 1'b0, 1'b1);
   endtask

   task automatic do_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int bcnt);
      @(posedge clk); #1;
      start = 1'b1;
      op = f3;
      a = x;
      b = y;
      flush = 1'b0;
      wait_done(res, lat, bcnt);
   endtask

   initial begin
      logic [31:0] r;
      int          lat, bc;
      logic [2:0]  rop;

      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk1("reset_busy", busy_o, 1'b0);
      chk32("reset_result", result_o, 32'h0);
      chk1("reset_done", done_o, 1'b0);
      #6 rst_n = 1'b1;

      do_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, bc);
      chk32("mul_7x-3", r, 32'hFFFF_FFEB);
      chk32("mul_latency", 32'(lat), 32'd33);
      chk32("mul_busy_cycles", 32'(bc), 32'd32);

      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc);
      chk32("mulhu_max", r, 32'hFFFF_FFFE);
      do_op(3'b010, 32'hFFFF_FFFF, 32'd2, r, lat, bc);
      chk32("mulhsu_-1x2", r, 32'hFFFF_FFFF);
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
      chk32("mulh_min", r, 32'h4000_0000);

`ifdef MULDIV_DIV_EN
      do_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
      chk32("div_-7/2", r, 32'hFFFF_FFFD);
      chk32("div_latency", 32'(lat), 32'd33);
      do_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
      chk32("rem_-7%2", r, 32'hFFFF_FFFF);
      do_op(3'b101, 32'd1234, 32'd0, r, lat, bc);
      chk32("divu_by0", r, 32'hFFFF_FFFF);
      chk32("divu_by0_latency", 32'(lat), 32'd33);
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
      chk32("div_overflow", r, 32'h8000_0000);
      do_op(3'b110, 32'hFFFF_FFF9, 32'd0, r, lat, bc);
      chk32("rem_by0", r, 32'hFFFF_FFF9);
`else
      do_op(3'b101, 32'd10, 32'd2, r, lat, bc);
      chk32("divu_nodiv_result", r, 32'h0);
      chk32("divu_nodiv_latency", 32'(lat), 32'd1);
      chk32("divu_nodiv_busy", 32'(bc), 32'd0);
`endif

      // Flush at busy cycle 10.
      do_op(3'b000, 32'd3, 32'd4, r, lat, bc);
      chk32("mul_3x4_pre", r, 32'd12);
      @(posedge clk); #1;
      start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      chk1("busy_before_flush", busy_o, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk1("flush_busy", busy_o, 1'b0);
      chk1("flush_done", done_o, 1'b0);
      chk32("flush_result_kept", result_o, 32'd12);
      start = 1'b1; op = 3'b011; a = 32'h0001_0000; b = 32'h0003_0000;
      #1 chk1("restart_stall", stall_o, 1'b1);
      wait_done(r, lat, bc);
      chk32("restart_mulhu", r, 32'h0000_0003);
      chk32("restart_latency", 32'(lat), 32'd33);

      // Asynchronous reset mid-operation.
      rop = DIV_EN ? 3'b100 : 3'b000;
      @(posedge clk); #1;
      start = 1'b1; op = rop; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk1("arst_busy", busy_o, 1'b0);
      chk1("arst_stall", stall_o, 1'b0);
      chk1("arst_done", done_o, 1'b0);
      chk32("arst_result", result_o, 32'h0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
      wait_done(r, lat, bc);
      chk32("post_reset_mul", r, 32'd12);
      chk32("post_reset_latency", 32'(lat), 32'd33);

      // Randomized traffic; the per-cycle compare process does the checking.
      for (int c = 0; c < 6000; c++) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 2) == 0);
         op = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         flush = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 1500) == 0) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
